// File: rtl/dest_data_demux.sv
// Steers the shared data-return stream to per-destination AXI-Stream outputs,
// following a FIFO of routing entries (dest/pid/len), one entry per transfer.
module dest_data_demux #(
    parameter int DATA_BITS = 64,
    parameter int N_DESTS = 1,
    parameter int PID_BITS = 6,
    parameter int BLEN_BITS = 8,
    localparam int N_DESTS_BITS = (N_DESTS > 1) ? $clog2(N_DESTS) : 1,
    localparam int KEEP_BITS = DATA_BITS / 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic                          s_mux_valid,
    output logic                          s_mux_ready,
    input  logic [N_DESTS_BITS-1:0]       s_mux_dest,
    input  logic [PID_BITS-1:0]           s_mux_pid,
    input  logic [BLEN_BITS-1:0]          s_mux_len,

    input  logic [DATA_BITS-1:0]          s_axis_tdata,
    input  logic [KEEP_BITS-1:0]          s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,

    output logic [N_DESTS*DATA_BITS-1:0]  m_axis_tdata,
    output logic [N_DESTS*KEEP_BITS-1:0]  m_axis_tkeep,
    output logic [N_DESTS-1:0]            m_axis_tlast,
    output logic [N_DESTS*PID_BITS-1:0]   m_axis_tid,
    output logic [N_DESTS-1:0]            m_axis_tvalid,
    input  logic [N_DESTS-1:0]            m_axis_tready,

    output logic                          err_tlast,
    output logic                          err_dest
);

    // state | meaning
    // IDLE  | waiting for a routing entry, input stalled
    // ROUTE | passing len+1 beats through to dest_r
    // DROP  | swallowing len+1 beats of an out-of-range entry
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUTE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]              state_r;
    logic [N_DESTS_BITS-1:0] dest_r;
    logic [PID_BITS-1:0]     pid_r;
    logic [BLEN_BITS-1:0]    cnt_r;

    logic last_cnt;
    logic in_tready;
    logic beat;
    logic entry_take;
    logic dest_ok;

    assign last_cnt   = (cnt_r == '0);
    assign in_tready  = (state_r == ST_DROP) | ((state_r == ST_ROUTE) & m_axis_tready[dest_r]);
    assign beat       = s_axis_tvalid & in_tready;
    // The next entry is taken on the final beat so consecutive transfers have no bubble.
    assign s_mux_ready   = aresetn & ((state_r == ST_IDLE) | (beat & last_cnt));
    assign s_axis_tready = in_tready;
    assign entry_take    = s_mux_valid & s_mux_ready;
    assign dest_ok       = ({1'b0, s_mux_dest} < (N_DESTS_BITS + 1)'(N_DESTS));

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = '0;
        m_axis_tid    = '0;
        m_axis_tvalid = '0;
        for (int d = 0; d < N_DESTS; d++) begin
            m_axis_tdata[d*DATA_BITS +: DATA_BITS] = s_axis_tdata;
            m_axis_tkeep[d*KEEP_BITS +: KEEP_BITS] = s_axis_tkeep;
            m_axis_tid[d*PID_BITS +: PID_BITS]     = pid_r;
            if ((state_r == ST_ROUTE) && (dest_r == N_DESTS_BITS'(d))) begin
                m_axis_tvalid[d] = s_axis_tvalid;
                m_axis_tlast[d]  = last_cnt;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r   <= ST_IDLE;
            dest_r    <= '0;
            pid_r     <= '0;
            cnt_r     <= '0;
            err_tlast <= 1'b0;
            err_dest  <= 1'b0;
        end else begin
            if (entry_take) begin
                dest_r <= s_mux_dest;
                pid_r  <= s_mux_pid;
                cnt_r  <= s_mux_len;
                if (dest_ok) begin
                    state_r <= ST_ROUTE;
                end else begin
                    state_r  <= ST_DROP;
                    err_dest <= 1'b1;
                end
            end else if (beat) begin
                if (last_cnt) begin
                    state_r <= ST_IDLE;
                end else begin
                    cnt_r <= cnt_r - 1'b1;
                end
            end
            // Input tlast is only audited; the beat count alone delimits transfers.
            if (beat && (s_axis_tlast != last_cnt)) begin
                err_tlast <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dest_data_demux.sv
// Randomized bench for dest_data_demux: a queue of expected beat slots
// (one per beat of every accepted entry) predicts every output each cycle.
module tb_dest_data_demux;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int ND = 3;
    localparam int PW = 4;
    localparam int LW = 3;

    logic            aclk;
    logic            aresetn;
    logic            s_mux_valid;
    logic            s_mux_ready;
    logic [1:0]      s_mux_dest;
    logic [PW-1:0]   s_mux_pid;
    logic [LW-1:0]   s_mux_len;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tlast;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [ND*DW-1:0] m_axis_tdata;
    logic [ND*KW-1:0] m_axis_tkeep;
    logic [ND-1:0]   m_axis_tlast;
    logic [ND*PW-1:0] m_axis_tid;
    logic [ND-1:0]   m_axis_tvalid;
    logic [ND-1:0]   m_axis_tready;
    logic            err_tlast;
    logic            err_dest;

    dest_data_demux #(
        .DATA_BITS (DW),
        .N_DESTS   (ND),
        .PID_BITS  (PW),
        .BLEN_BITS (LW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_mux_valid   (s_mux_valid),
        .s_mux_ready   (s_mux_ready),
        .s_mux_dest    (s_mux_dest),
        .s_mux_pid     (s_mux_pid),
        .s_mux_len     (s_mux_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .err_tlast     (err_tlast),
        .err_dest      (err_dest)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]    dest;
        logic [PW-1:0] pid;
        logic [LW-1:0] len;
    } ent_t;

    typedef struct {
        int            dest;
        logic [PW-1:0] pid;
        bit            last;
        bit            drop;
    } slot_t;

    ent_t  ent_q[$];
    slot_t slot_q[$];
    bit    exp_err_tlast;
    bit    exp_err_dest;
    int    delivered[ND];
    int    total;
    int    pass_cnt;

    function automatic ent_t mk(input int d, input int p, input int l);
        ent_t e;
        e.dest = 2'(d);
        e.pid  = PW'(p);
        e.len  = LW'(l);
        return e;
    endfunction

    task automatic clear_delivered();
        for (int d = 0; d < ND; d++) delivered[d] = 0;
    endtask

    task automatic idle_inputs();
        s_mux_valid   = 1'b0;
        s_mux_dest    = '0;
        s_mux_pid     = '0;
        s_mux_len     = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = '1;
    endtask

    // Drives entries from ent_q and n_beats input beats; checks every output each cycle.
    // rdy_mode: 0 all ready, 1 all toggle each cycle, 2 random. abort_after < 0 runs to completion.
    task automatic run(input int n_beats, input int rdy_mode, input bit gaps,
                       input int bad_tlast_idx, input int abort_after, input int budget,
                       output int cycles);
        int sent = 0;
        int cyc = 0;
        bit exp_rdy;
        bit exp_mrdy;
        bit hs;
        logic [ND-1:0] exp_tv;
        logic [ND-1:0] exp_tl;
        ent_t e;
        while ((ent_q.size() > 0 || slot_q.size() > 0 || sent < n_beats) &&
               !(abort_after >= 0 && sent >= abort_after)) begin
            if (cyc >= budget) begin
                total++;
                $display("FAIL timeout: %0d cycles, sent %0d of %0d beats", cyc, sent, n_beats);
                break;
            end
            @(negedge aclk);
            if (ent_q.size() > 0) begin
                s_mux_valid = 1'b1;
                s_mux_dest  = ent_q[0].dest;
                s_mux_pid   = ent_q[0].pid;
                s_mux_len   = ent_q[0].len;
            end else begin
                s_mux_valid = 1'b0;
            end
            s_axis_tvalid = (sent < n_beats) && (!gaps || $urandom_range(0, 3) != 0);
            s_axis_tdata  = $urandom;
            s_axis_tkeep  = KW'($urandom);
            if (bad_tlast_idx >= 0) s_axis_tlast = (sent == bad_tlast_idx);
            else s_axis_tlast = (slot_q.size() > 0) && slot_q[0].last;
            case (rdy_mode)
                0: m_axis_tready = '1;
                1: m_axis_tready = (cyc % 2 == 0) ? '1 : '0;
                default: m_axis_tready = ND'($urandom);
            endcase
            #1;
            if (slot_q.size() == 0) exp_rdy = 1'b0;
            else if (slot_q[0].drop) exp_rdy = 1'b1;
            else exp_rdy = m_axis_tready[slot_q[0].dest];
            hs = s_axis_tvalid && exp_rdy;
            exp_mrdy = (slot_q.size() == 0) || (slot_q.size() == 1 && hs);
            exp_tv = '0;
            exp_tl = '0;
            if (slot_q.size() > 0 && !slot_q[0].drop) begin
                exp_tv[slot_q[0].dest] = s_axis_tvalid;
                exp_tl[slot_q[0].dest] = slot_q[0].last;
            end
            total++;
            if (s_axis_tready !== exp_rdy)
                $display("FAIL s_axis_tready cyc %0d: got %b want %b", cyc, s_axis_tready, exp_rdy);
            else pass_cnt++;
            total++;
            if (s_mux_ready !== exp_mrdy)
                $display("FAIL s_mux_ready cyc %0d: got %b want %b", cyc, s_mux_ready, exp_mrdy);
            else pass_cnt++;
            total++;
            if (m_axis_tvalid !== exp_tv)
                $display("FAIL m_axis_tvalid cyc %0d: got %b want %b", cyc, m_axis_tvalid, exp_tv);
            else pass_cnt++;
            total++;
            if (m_axis_tlast !== exp_tl)
                $display("FAIL m_axis_tlast cyc %0d: got %b want %b", cyc, m_axis_tlast, exp_tl);
            else pass_cnt++;
            if (slot_q.size() > 0 && !slot_q[0].drop && s_axis_tvalid) begin
                total++;
                if (m_axis_tdata[slot_q[0].dest*DW +: DW] !== s_axis_tdata ||
                    m_axis_tkeep[slot_q[0].dest*KW +: KW] !== s_axis_tkeep ||
                    m_axis_tid[slot_q[0].dest*PW +: PW] !== slot_q[0].pid)
                    $display("FAIL beat payload dest %0d: got %h/%h/%h want %h/%h/%h", slot_q[0].dest,
                             m_axis_tdata[slot_q[0].dest*DW +: DW], m_axis_tkeep[slot_q[0].dest*KW +: KW],
                             m_axis_tid[slot_q[0].dest*PW +: PW], s_axis_tdata, s_axis_tkeep, slot_q[0].pid);
                else pass_cnt++;
            end
            total++;
            if (err_tlast !== exp_err_tlast || err_dest !== exp_err_dest)
                $display("FAIL err flags cyc %0d: got tlast=%b dest=%b want tlast=%b dest=%b",
                         cyc, err_tlast, err_dest, exp_err_tlast, exp_err_dest);
            else pass_cnt++;
            if (hs) begin
                if (s_axis_tlast != slot_q[0].last) exp_err_tlast = 1'b1;
                if (!slot_q[0].drop) delivered[slot_q[0].dest]++;
                void'(slot_q.pop_front());
                sent++;
            end
            if (s_mux_valid && exp_mrdy) begin
                e = ent_q.pop_front();
                if (e.dest >= ND) exp_err_dest = 1'b1;
                for (int i = 0; i <= int'(e.len); i++)
                    slot_q.push_back('{int'(e.dest), e.pid, (i == int'(e.len)), (e.dest >= ND)});
            end
            cyc++;
        end
        cycles = cyc;
        @(negedge aclk);
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        total++;
        if (s_mux_ready !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tvalid !== '0)
            $display("FAIL reset_hold: got mrdy=%b trdy=%b tvalid=%b want 0/0/000",
                     s_mux_ready, s_axis_tready, m_axis_tvalid);
        else pass_cnt++;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        total++;
        if (s_mux_ready !== 1'b1 || s_axis_tready !== 1'b0 || err_tlast !== 1'b0 || err_dest !== 1'b0)
            $display("FAIL reset_release: got mrdy=%b trdy=%b errs=%b%b want 1/0/00",
                     s_mux_ready, s_axis_tready, err_tlast, err_dest);
        else pass_cnt++;
        slot_q.delete();
        ent_q.delete();
        exp_err_tlast = 1'b0;
        exp_err_dest  = 1'b0;
    endtask

    task automatic test_single();
        int cyc;
        clear_delivered();
        ent_q.push_back(mk(2, 5, 3));
        run(4, 0, 1'b0, -1, -1, 50, cyc);
        total++;
        if (delivered[2] !== 4 || delivered[0] !== 0 || delivered[1] !== 0)
            $display("FAIL single_counts: got %0d/%0d/%0d want 0/0/4", delivered[0], delivered[1], delivered[2]);
        else pass_cnt++;
        total++;
        if (err_tlast !== 1'b0 || err_dest !== 1'b0)
            $display("FAIL single_errs: got %b%b want 00", err_tlast, err_dest);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        clear_delivered();
        ent_q.push_back(mk(0, 1, 0));
        ent_q.push_back(mk(1, 2, 1));
        run(3, 0, 1'b0, -1, -1, 50, cyc);
        total++;
        if (cyc !== 4)
            $display("FAIL b2b_cycles: got %0d want 4", cyc);
        else pass_cnt++;
        total++;
        if (delivered[0] !== 1 || delivered[1] !== 2)
            $display("FAIL b2b_counts: got %0d/%0d want 1/2", delivered[0], delivered[1]);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int cyc;
        clear_delivered();
        ent_q.push_back(mk(1, 7, 7));
        run(8, 1, 1'b0, -1, -1, 100, cyc);
        total++;
        if (delivered[1] !== 8)
            $display("FAIL bp_count: got %0d want 8", delivered[1]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int cyc;
        int n = 0;
        int exp_cnt[ND];
        ent_t e;
        clear_delivered();
        for (int d = 0; d < ND; d++) exp_cnt[d] = 0;
        for (int i = 0; i < 25; i++) begin
            e = mk($urandom_range(0, ND - 1), $urandom_range(0, 15), $urandom_range(0, 7));
            ent_q.push_back(e);
            n += int'(e.len) + 1;
            exp_cnt[e.dest] += int'(e.len) + 1;
        end
        run(n, 2, 1'b1, -1, -1, 3000, cyc);
        for (int d = 0; d < ND; d++) begin
            total++;
            if (delivered[d] !== exp_cnt[d])
                $display("FAIL random_count dest %0d: got %0d want %0d", d, delivered[d], exp_cnt[d]);
            else pass_cnt++;
        end
    endtask

    task automatic test_tlast_err();
        int cyc;
        clear_delivered();
        ent_q.push_back(mk(0, 9, 3));
        run(4, 0, 1'b0, 1, -1, 50, cyc);
        total++;
        if (delivered[0] !== 4 || err_tlast !== 1'b1)
            $display("FAIL tlast_err: got beats=%0d err=%b want 4/1", delivered[0], err_tlast);
        else pass_cnt++;
    endtask

    task automatic test_drop();
        int cyc;
        clear_delivered();
        ent_q.push_back(mk(3, 4, 2));
        run(3, 0, 1'b0, -1, -1, 50, cyc);
        repeat (3) @(negedge aclk);
        #1;
        total++;
        if (err_dest !== 1'b1 || delivered[0] + delivered[1] + delivered[2] !== 0 || cyc !== 4)
            $display("FAIL drop: got err=%b delivered=%0d cycles=%0d want 1/0/4", err_dest,
                     delivered[0] + delivered[1] + delivered[2], cyc);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        clear_delivered();
        ent_q.push_back(mk(0, 3, 4));
        run(5, 0, 1'b0, -1, 2, 50, cyc);
        aresetn = 1'b0;
        s_axis_tvalid = 1'b1;
        #1;
        total++;
        if (s_mux_ready !== 1'b0)
            $display("FAIL midreset_mrdy: got %b want 0", s_mux_ready);
        else pass_cnt++;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        total++;
        if (m_axis_tvalid !== '0 || s_axis_tready !== 1'b0 || err_tlast !== 1'b0 || err_dest !== 1'b0)
            $display("FAIL midreset_outs: got tvalid=%b trdy=%b errs=%b%b want 000/0/00",
                     m_axis_tvalid, s_axis_tready, err_tlast, err_dest);
        else pass_cnt++;
        idle_inputs();
        slot_q.delete();
        exp_err_tlast = 1'b0;
        exp_err_dest  = 1'b0;
        clear_delivered();
        ent_q.push_back(mk(0, 6, 0));
        run(1, 0, 1'b0, -1, -1, 20, cyc);
        total++;
        if (delivered[0] !== 1)
            $display("FAIL midreset_next: got %0d beats want 1", delivered[0]);
        else pass_cnt++;
    endtask

    initial begin
        total = 0;
        pass_cnt = 0;
        exp_err_tlast = 1'b0;
        exp_err_dest = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_tlast_err();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/dest_data_demux.md
Name: dest_data_demux

Overview:
- Downstream counterpart of the per-destination request arbiter.
- Consumes the routing-sequence stream (one entry of dest/pid/len per arbitrated request) and steers the single returning data stream to N_DESTS output streams.
- Each entry covers exactly len+1 beats and is applied in FIFO order.
- Sits between the shared data-return path and the per-destination user-logic streams.

Parameters:
DATA_BITS, AXI_DATA_BITS, data beat width in bits.
N_DESTS, 1, number of destination streams; N_DESTS_BITS = clog2s(N_DESTS).

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_mux_valid  in  1  sequence entry valid
s_mux_ready  out  1  sequence entry accepted
s_mux_dest  in  N_DESTS_BITS  target destination index
s_mux_pid  in  PID_BITS  process id of transfer
s_mux_len  in  BLEN_BITS  beats in transfer minus 1
s_axis_tdata  in  DATA_BITS  shared input data
s_axis_tkeep  in  DATA_BITS/8  byte enables
s_axis_tlast  in  1  input last marker (checked only)
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  N_DESTS x DATA_BITS  per-dest data
m_axis_tkeep  out  N_DESTS x DATA_BITS/8  per-dest byte enables
m_axis_tlast  out  N_DESTS  per-dest last
m_axis_tid  out  N_DESTS x PID_BITS  per-dest pid of current transfer
m_axis_tvalid  out  N_DESTS  per-dest valid
m_axis_tready  in  N_DESTS  per-dest ready
err_tlast  out  1  sticky: input tlast disagreed with beat count
err_dest  out  1  sticky: entry with dest >= N_DESTS received

Behaviour:
- Clock aclk; reset aresetn, synchronous, active-low.
- Reset values:
  - FSM enters IDLE; dest_r, pid_r, cnt_r return to 0; err_tlast and err_dest return to 0.
  - All m_axis_tvalid = 0, s_axis_tready = 0.
  - s_mux_ready = 0 while aresetn low.
- FSM states: IDLE, ROUTE, DROP.
- IDLE:
  - s_mux_ready = 1; s_axis_tready = 0; no m_axis_tvalid asserted.
  - On s_mux_valid & s_mux_ready: latch dest_r, pid_r, and cnt_r = s_mux_len.
  - Go to ROUTE if s_mux_dest < N_DESTS; otherwise go to DROP and set err_dest.
- ROUTE:
  - Combinational pass-through, zero latency:
    - m_axis_tvalid[dest_r] = s_axis_tvalid.
    - s_axis_tready = m_axis_tready[dest_r].
    - tdata/tkeep driven to dest_r; tid = pid_r.
    - m_axis_tlast[dest_r] = (cnt_r == 0).
  - Other destinations hold tvalid = 0. Their tdata/tkeep may mirror the input, but tlast must be 0.
  - Beat handshake = s_axis_tvalid & s_axis_tready.
  - On a beat with cnt_r != 0: cnt_r decrements.
  - On a beat with cnt_r == 0 (last beat):
    - s_mux_ready = 1 in the same cycle.
    - If a new valid entry is present, it is latched and the FSM re-enters ROUTE/DROP with no bubble.
    - Otherwise go to IDLE.
  - Outside the last beat, s_mux_ready = 0 in ROUTE.
- DROP:
  - Same counting and last-beat transitions as ROUTE.
  - s_axis_tready = 1; no output valid; data discarded.
- tlast check:
  - On every input beat in ROUTE/DROP, if s_axis_tlast != (cnt_r == 0), set err_tlast.
  - Routing follows cnt_r only; input tlast never ends a transfer early.
  - err_tlast and err_dest clear only on reset.
- Counter is BLEN_BITS wide:
  - len = 0 means 1 beat.
  - Max len (all ones) gives 2^BLEN_BITS beats without wrap.
- Input beats arriving in IDLE are not accepted (tready = 0) and stall until an entry arrives.
- Backpressure on one destination stalls the whole input; this is intentional, to preserve ordering.
- N_DESTS = 1: dest is 1 bit; dest 1 is out-of-range and goes to DROP.
- Reset mid-transfer: FSM and counter abort immediately; partial transfer is not completed; outputs go to reset values in the next cycle.

Test Plan:
- Reset, then entry {dest=2, pid=5, len=3}, 4 input beats with tlast on beat 4, all readies 1 → m_axis[2] gets 4 beats, tid=5, tlast only on beat 4; m_axis[0,1,3] tvalid never 1; err flags 0.
- Back-to-back entries {dest=0, len=0} and {dest=1, len=1} pre-queued, continuous input → beat 1 goes to dest0 with tlast; beats 2–3 go to dest1 with no idle cycle; s_mux_ready pulses on the last-beat cycles.
- Entry {dest=1, len=7}, m_axis_tready[1] toggles 1/0 every cycle, input always valid → 8 beats delivered in order, s_axis_tready mirrors tready[1], no data lost or duplicated.
- N_DESTS=3, entry {dest=3, len=2} → 3 input beats accepted and dropped, no output valid, err_dest = 1 and stays 1.
- Entry {len=3}, input tlast asserted on beat 2 → routing continues to beat 4 with output tlast on beat 4; err_tlast = 1 from beat 2 onward.
- Assert aresetn low for 1 cycle after 2 of 5 beats → all outputs return to reset values; next entry {dest=0, len=0} routes 1 beat correctly.
